// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: 4-requester round-robin arbiter that drives a registered
// select for a 4:1 data mux and a registered shared-resource output.
// Optional per-owner hold timeout is compiled in with `define ARB_TIMEOUT_EN
// (HOLD_MAX consecutive grant cycles per owner). Without the macro an owner
// keeps the grant for as long as its request stays high.
module mux_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  output logic [3:0] grant,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic       out
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, nstate;
  logic [1:0] ptr;       // last owner; search starts one above it
  logic [1:0] sel;       // current (or last) owner, drives the mux select
  logic [3:0] cand;      // requests eligible to win this edge
  logic [1:0] win;
  logic       win_vld;
  logic       take;      // a new owner is installed on this edge
  logic       timeout;
  logic [3:0] din;

  assign din = {i3, i2, i1, i0};

`ifdef ARB_TIMEOUT_EN
  logic [3:0] hold;
  assign timeout = (hold == 4'(HOLD_MAX - 1));
`else
  assign timeout = 1'b0;
`endif

  // Candidate set: the current owner is never eligible while it holds, so a
  // same-edge release/re-request cannot re-win.
  always_comb begin
    cand = req;
    if (state == GRANT)
      cand = req & ~(4'b0001 << sel);
  end

  // Round-robin search from ptr+1 upward with wrap-around.
  always_comb begin
    logic [1:0] idx;
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!win_vld && cand[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  // Next-state logic: arbitrate from IDLE, hand off or drop to IDLE on release.
  always_comb begin
    nstate = state;
    take   = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          nstate = GRANT;
          take   = 1'b1;
        end
      end
      GRANT: begin
        if (!req[sel] || timeout) begin
          if (win_vld) take = 1'b1;
          else         nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // State register plus owner/pointer/hold bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd3;
      sel   <= 2'd0;
`ifdef ARB_TIMEOUT_EN
      hold  <= '0;
`endif
    end else begin
      state <= nstate;
      if (take) begin
        ptr <= win;
        sel <= win;
      end
`ifdef ARB_TIMEOUT_EN
      if (take)
        hold <= '0;
      else if (state == GRANT && hold != 4'hf)
        hold <= hold + 4'd1;
`endif
    end
  end

  // Grant/select/busy decode straight from registers, so they move together.
  always_comb begin
    busy     = (state == GRANT);
    grant    = busy ? (4'b0001 << sel) : '0;
    {s1, s0} = sel;
  end

  // Shared-resource output: registered mux of the selected input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= 1'b0;
    else     out <= busy ? din[sel] : 1'b0;
  end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 SHALL have parameter: HOLD_MAX, 8, maximum consecutive grant cycles per owner when timeout is compiled in (legal 2..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: req  input  4  request from requester n on bit n; level-held while service wanted.
REQ-005 SHALL have port: i0, i1, i2, i3  input  1 each  data from requesters 0..3.
REQ-006 SHALL have port: grant  output  4  one-hot registered grant; all-zero when idle.
REQ-007 SHALL have port: s1, s0  output  1 each  registered mux select; {s1,s0} = binary index of owner.
REQ-008 SHALL have port: busy  output  1  high while any grant bit is high.
REQ-009 SHALL have port: out  output  1  registered shared-resource output.

Function
REQ-010 SHALL implement two states: IDLE (no owner) and GRANT (one owner).
REQ-011 SHALL keep a 2-bit last-owner pointer; the search for a winner starts at pointer+1 (mod 4) and proceeds upward with wrap-around.
REQ-012 IDLE: any req bit high at an edge -> GRANT with the round-robin winner; grant, {s1,s0} and busy valid one cycle after req is sampled.
REQ-013 IDLE: req == 0 -> remain IDLE; grant = 0, busy = 0, {s1,s0} hold last value.
REQ-014 GRANT: owner's req high and no timeout -> owner, grant and select unchanged.
REQ-015 GRANT release: owner's req low, or timeout (REQ-024) -> choose a winner among req bits excluding the current owner; winner exists -> new owner on the same edge (direct handoff, no idle cycle); else -> IDLE.
REQ-016 On every new grant, the pointer SHALL take the new owner index and the hold counter SHALL clear to 0.
REQ-017 Hold counter: 4-bit, increments each GRANT cycle with an unchanged owner; saturates at 15.
REQ-018 grant SHALL never have more than one bit set; grant, {s1,s0} and busy SHALL change only on the same edge.
REQ-019 out SHALL update each edge to the selected input (i0..i3 indexed by the current registered {s1,s0}) when busy = 1, else 0; one-cycle latency from input change.
REQ-020 Simultaneous release by owner and new req from the same requester on that edge: the requester is excluded from the winner search for that edge.

Reset
REQ-021 rst high SHALL immediately force: state IDLE, grant = 4'b0000, s1 = s0 = 0, busy = 0, out = 0, hold counter = 0, pointer = 3 (requester 0 has first priority).
REQ-022 Reset asserted mid-grant SHALL abandon the grant with no handoff; first arbitration after release follows REQ-012 from the reset pointer.
REQ-023 Deassertion of rst SHALL take effect at the next rising edge of clk.

Configuration
REQ-024 With ARB_TIMEOUT_EN defined: when the hold counter equals HOLD_MAX-1 with the owner's req still high, the edge SHALL act as a release (REQ-015); the owner holds for exactly HOLD_MAX cycles and may regain grant only once no other requester is pending.
REQ-025 Without ARB_TIMEOUT_EN: no timeout; an owner keeps grant for as long as its req stays high; the hold counter may be omitted.

Verification
REQ-026 Reset, then req=0001, i0=1 -> after 1 edge grant=0001, {s1,s0}=00, busy=1; after 2 edges out=1.
REQ-027 req=1111 held; each owner drops its bit for one cycle after receiving grant -> grant order 0001,0010,0100,1000,0001, each handoff with no idle cycle.
REQ-028 ARB_TIMEOUT_EN, HOLD_MAX=4, req=0011 held -> grant=0001 for exactly 4 cycles, then 0010 for 4 cycles, then 0001.
REQ-029 No macro, req=0011 held 20 cycles -> grant stays 0001 for all 20 cycles.
REQ-030 Owner 2 holding, rst pulsed asynchronously mid-cycle -> grant, busy, out zero immediately; after release req=0100 -> grant=0100, {s1,s0}=10.
REQ-031 Owner 1 drops req with req otherwise 0 -> next edge grant=0000, busy=0, out=0 one edge later; {s1,s0} stays 01.
